// File: rtl/gf_op_sequencer_if.sv
// ============================================================================
// Module   : gf_op_sequencer_if
// Brief    : Request, response and core-side bus bundle for gf_op_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface gf_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_err;
    logic        rsp_timeout;

    logic        core_mode;
    logic [1:0]  core_operation;
    logic        core_valid_in;
    logic [31:0] core_a32;
    logic [31:0] core_b32;
    logic [15:0] core_a16;
    logic [15:0] core_b16;
    logic [31:0] core_result32;
    logic [15:0] core_result16;
    logic        core_valid_out;
    logic        core_overflow;

    // Sequencer side: initiator towards the core, target of the request port.
    modport master (
        input  req_valid, req_mode, req_op, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_data, rsp_ovf, rsp_err, rsp_timeout,
        input  rsp_ready,
        output core_mode, core_operation, core_valid_in,
        output core_a32, core_b32, core_a16, core_b16,
        input  core_result32, core_result16, core_valid_out, core_overflow
    );

    // Environment side: upstream requester, downstream consumer and the core.
    modport slave (
        output req_valid, req_mode, req_op, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_ovf, rsp_err, rsp_timeout,
        output rsp_ready,
        input  core_mode, core_operation, core_valid_in,
        input  core_a32, core_b32, core_a16, core_b16,
        output core_result32, core_result16, core_valid_out, core_overflow
    );
endinterface

`default_nettype wire

// File: rtl/gf_op_sequencer.sv
// ============================================================================
// Module   : gf_op_sequencer
// Brief    : Issues one greenfloat core op at a time and returns its result.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gf_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STAT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    gf_op_sequencer_if.master  bus,
    output logic [STAT_W-1:0]  stat_issued,
    output logic [STAT_W-1:0]  stat_timeouts
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] c_timer_last = 8'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    logic               r_mode;
    logic [1:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [7:0]         r_timer;
    logic               r_valid_in;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_ovf;
    logic               r_rsp_err;
    logic               r_rsp_timeout;
    logic [STAT_W-1:0]  r_issued;
    logic [STAT_W-1:0]  r_timeouts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_op          <= 2'b00;
            r_a           <= 32'h0;
            r_b           <= 32'h0;
            r_timer       <= 8'h0;
            r_valid_in    <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 32'h0;
            r_rsp_ovf     <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_issued      <= '0;
            r_timeouts    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_mode <= bus.req_mode;
                        r_op   <= bus.req_op;
                        r_a    <= bus.req_a;
                        r_b    <= bus.req_b;
                        if (bus.req_op == 2'b00 || bus.req_op == 2'b10) begin
                            r_valid_in <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end

                S_ISSUE: begin
                    r_valid_in <= 1'b0;
                    r_timer    <= 8'h0;
                    if (r_issued != {STAT_W{1'b1}}) begin
                        r_issued <= r_issued + 1'b1;
                    end
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // A result on the final timer cycle still beats the timeout.
                    if (bus.core_valid_out) begin
                        r_rsp_data  <= r_mode ? {16'h0, bus.core_result16} : bus.core_result32;
                        r_rsp_ovf   <= bus.core_overflow;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_timer == c_timer_last) begin
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= 32'h0;
                        r_rsp_ovf     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        if (r_timeouts != {STAT_W{1'b1}}) begin
                            r_timeouts <= r_timeouts + 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_data    <= 32'h0;
                        r_rsp_ovf     <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_ovf        = r_rsp_ovf;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.rsp_timeout    = r_rsp_timeout;

    // The core output mux is combinational on mode/operation, so these come
    // straight from the registers latched at request acceptance.
    assign bus.core_mode      = r_mode;
    assign bus.core_operation = r_op;
    assign bus.core_valid_in  = r_valid_in;
    assign bus.core_a32       = r_a;
    assign bus.core_b32       = r_b;
    assign bus.core_a16       = r_a[15:0];
    assign bus.core_b16       = r_b[15:0];

    assign stat_issued        = r_issued;
    assign stat_timeouts      = r_timeouts;

endmodule

`default_nettype wire

// File: tb/tb_gf_op_sequencer.sv
// ============================================================================
// Module   : tb_gf_op_sequencer
// Brief    : Directed bench with a stub core and a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gf_op_sequencer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stat_issued;
    logic [15:0] stat_timeouts;

    gf_op_sequencer_if bus ();

    gf_op_sequencer #(.TIMEOUT_CYCLES(T), .STAT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stat_issued   (stat_issued),
        .stat_timeouts (stat_timeouts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub core: pulses valid_out stub_lat cycles after seeing valid_in
    // (0 = never answers); results are only correct during the pulse.
    int          stub_lat = 0;
    int          stub_cnt = 0;
    logic [31:0] stub_r32 = 32'h0;
    logic [15:0] stub_r16 = 16'h0;
    logic        stub_ovf = 1'b0;

    initial begin
        bus.core_valid_out = 1'b0;
        bus.core_result32  = 32'h0;
        bus.core_result16  = 16'h0;
        bus.core_overflow  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.core_valid_out = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) bus.core_valid_out = 1'b1;
            end
            if (bus.core_valid_in === 1'b1 && stub_lat > 0) stub_cnt = stub_lat;
            bus.core_result32 = bus.core_valid_out ? stub_r32 : ~stub_r32;
            bus.core_result16 = bus.core_valid_out ? stub_r16 : ~stub_r16;
            bus.core_overflow = bus.core_valid_out ? stub_ovf : ~stub_ovf;
        end
    end

    // Transaction model: on acceptance it predicts when the response appears
    // (from stub latency and the timeout budget) and what it carries.
    logic        m_busy = 1'b0, m_legal = 1'b0, m_to = 1'b0, m_ovf = 1'b0, m_mode = 1'b0, m_rv;
    logic [1:0]  m_op = 2'b00;
    logic [31:0] m_a = 32'h0, m_b = 32'h0, m_data = 32'h0;
    int          m_acc = 0, m_start = 0, m_issued = 0, m_touts = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_legal = 1'b0; m_to = 1'b0; m_mode = 1'b0; m_op = 2'b00;
            m_a = 32'h0; m_b = 32'h0; m_issued = 0; m_touts = 0;
            chk("rst_req_ready", bus.req_ready, 1'b1);
            chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk("rst_core_valid_in", bus.core_valid_in, 1'b0);
            chk("rst_rsp_data", bus.rsp_data, 32'h0);
            chk("rst_core_a32", bus.core_a32, 32'h0);
            chk("rst_stat_issued", stat_issued, 32'h0);
            chk("rst_stat_timeouts", stat_timeouts, 32'h0);
        end else begin
            m_rv = m_busy && (cyc >= m_start);
            chk("req_ready", bus.req_ready, !m_busy);
            chk("core_valid_in", bus.core_valid_in, m_busy && m_legal && (cyc == m_acc + 1));
            chk("rsp_valid", bus.rsp_valid, m_rv);
            chk("rsp_data", bus.rsp_data, m_rv ? m_data : 32'h0);
            chk("rsp_ovf", bus.rsp_ovf, m_rv && m_ovf);
            chk("rsp_err", bus.rsp_err, m_rv && !m_legal);
            chk("rsp_timeout", bus.rsp_timeout, m_rv && m_to);
            chk("core_mode", bus.core_mode, m_mode);
            chk("core_operation", bus.core_operation, m_op);
            chk("core_a32", bus.core_a32, m_a);
            chk("core_b32", bus.core_b32, m_b);
            chk("core_a16", bus.core_a16, m_a[15:0]);
            chk("core_b16", bus.core_b16, m_b[15:0]);
            chk("stat_issued", stat_issued,
                (m_busy && m_legal && cyc < m_acc + 2) ? m_issued - 1 : m_issued);
            chk("stat_timeouts", stat_timeouts,
                (m_busy && m_to && cyc < m_start) ? m_touts - 1 : m_touts);

            if (!m_busy && bus.req_valid) begin
                m_busy  = 1'b1;
                m_acc   = cyc;
                m_mode  = bus.req_mode;
                m_op    = bus.req_op;
                m_a     = bus.req_a;
                m_b     = bus.req_b;
                m_legal = (m_op == 2'b00) || (m_op == 2'b10);
                m_to    = m_legal && (stub_lat == 0 || stub_lat > T);
                if (!m_legal) begin
                    m_start = cyc + 1;
                    m_data  = 32'h0;
                    m_ovf   = 1'b0;
                end else if (m_to) begin
                    m_start = cyc + 2 + T;
                    m_data  = 32'h0;
                    m_ovf   = 1'b0;
                    m_touts++;
                end else begin
                    m_start = cyc + 2 + stub_lat;
                    m_data  = m_mode ? {16'h0, stub_r16} : stub_r32;
                    m_ovf   = stub_ovf;
                end
                if (m_legal) m_issued++;
            end else if (m_rv && bus.rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic wait_accept(input string tag);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
        end
        if (!ok) chk({tag, "_accept_timeout"}, 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic mode, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] r32, input logic [15:0] r16, input logic ovf,
                          input int rdy_delay, input bit hold_next,
                          input logic [31:0] lit_data, input logic lit_ovf,
                          input logic lit_err, input logic lit_to);
        bit ok = 0;
        stub_lat = lat; stub_r32 = r32; stub_r16 = r16; stub_ovf = ovf;
        bus.req_mode = mode; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.req_valid = 1'b1;
        wait_accept(tag);
        // Scramble request inputs so a re-latch would be visible.
        bus.req_valid = 1'b0; bus.req_a = ~a; bus.req_b = ~b;
        bus.req_mode = ~mode; bus.req_op = op ^ 2'b10;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) ok = 1;
        end
        if (!ok) chk({tag, "_rsp_timeout"}, 32'h0, 32'h1);
        chk({tag, "_data"}, bus.rsp_data, lit_data);
        chk({tag, "_ovf"}, bus.rsp_ovf, lit_ovf);
        chk({tag, "_err"}, bus.rsp_err, lit_err);
        chk({tag, "_timeout"}, bus.rsp_timeout, lit_to);
        @(posedge clk);
        #1;
        if (hold_next) begin
            bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.req_a = 32'hDEAD_BEEF;
        end
        repeat (rdy_delay) begin
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_mode = 1'b0; bus.req_op = 2'b00;
        bus.req_a = 32'h0; bus.req_b = 32'h0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_req_ready", bus.req_ready, 1'b1);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);

        run_op("fp32_add", 1'b0, 2'b00, 32'h3F80_0000, 32'h4000_0000, 3,
               32'h4040_0000, 16'h1234, 1'b0, 0, 0, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
        chk("fp32_add_stat_issued", stat_issued, 32'd1);

        run_op("fp16_mul", 1'b1, 2'b10, 32'h0000_4000, 32'h0000_4200, 5,
               32'hAAAA_5555, 16'h4600, 1'b0, 2, 0, 32'h0000_4600, 1'b0, 1'b0, 1'b0);
        chk("fp16_core_a16", bus.core_a16, 32'h4000);
        chk("fp16_core_b16", bus.core_b16, 32'h4200);

        run_op("illegal01", 1'b0, 2'b01, 32'h1111_1111, 32'h2222_2222, 2,
               32'h5555_5555, 16'h5555, 1'b1, 0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("illegal01_stat_issued", stat_issued, 32'd2);

        // Core answers at latency 20: late pulse lands while the response waits.
        run_op("timeout", 1'b0, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 20,
               32'h4000_0000, 16'h0, 1'b1, 5, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("timeout_stat_timeouts", stat_timeouts, 32'd1);

        run_op("after_to_mul", 1'b0, 2'b10, 32'h7F00_0000, 32'h7F00_0000, 1,
               32'h7F80_0000, 16'h0, 1'b1, 0, 0, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);

        run_op("lat16_wins", 1'b1, 2'b00, 32'h0000_3C00, 32'h0000_3C00, 16,
               32'h0, 16'h4000, 1'b0, 0, 0, 32'h0000_4000, 1'b0, 1'b0, 1'b0);

        run_op("lat17_to", 1'b1, 2'b00, 32'h0000_3C00, 32'h0000_3C00, 17,
               32'h0, 16'h4000, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("lat17_stat_timeouts", stat_timeouts, 32'd2);

        run_op("backpressure", 1'b0, 2'b00, 32'h0101_0101, 32'h0202_0202, 4,
               32'h1234_5678, 16'h0, 1'b0, 10, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

        run_op("illegal11", 1'b1, 2'b11, 32'h0000_ABCD, 32'h0000_1234, 0,
               32'h0, 16'h0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("illegal11_stat_issued", stat_issued, 32'd7);

        // Abort an op mid-WAIT; its pending core answer must be ignored.
        stub_lat = 10; stub_r32 = 32'h7777_7777;
        bus.req_mode = 1'b0; bus.req_op = 2'b00;
        bus.req_a = 32'h4080_0000; bus.req_b = 32'h4080_0000; bus.req_valid = 1'b1;
        wait_accept("reset_op");
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_core_valid_in", bus.core_valid_in, 1'b0);
        chk("async_rst_core_a32", bus.core_a32, 32'h0);
        chk("async_rst_core_mode", bus.core_mode, 1'b0);
        chk("async_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("async_rst_stat_issued", stat_issued, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1'b1);
        chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);

        run_op("post_rst_add", 1'b0, 2'b00, 32'h3F80_0000, 32'h4000_0000, 2,
               32'h4040_0000, 16'h0, 1'b0, 1, 0, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_stat_issued", stat_issued, 32'd1);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
